// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES core scheduler.
// The FSM state type is also exported so the state can be observed on a debug port.
package aes_sched_pkg;

  localparam int AES_BLK_W = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ENC_LD,
    DEC_KLD,
    DEC_KWAIT,
    DEC_LD,
    WAIT,
    RESP
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter: the lowest requester at or above ptr wins,
// otherwise the search wraps around to the lowest requester overall.
module aes_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IW'(i) >= ptr);
    end
    masked = req & mask;
    pick   = (|masked) ? masked : req;
    // Isolate the lowest set bit of the chosen request vector.
    grant  = pick & (~pick + N'(1));
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one AES encrypt core and one AES decrypt core between NUM_REQ requesters,
// sequencing key expansion, block load and completion, and returning tagged responses.
module aes_core_scheduler
  import aes_sched_pkg::*;
#(
  parameter int  NUM_REQ        = 2,
  parameter int  KEY_EXP_CYCLES = 10,
  parameter int  TIMEOUT        = 64,
  localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ-1:0]           req_mode_i,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_key_i,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_text_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [ID_W-1:0]              rsp_id_o,
  output logic [AES_BLK_W-1:0]         rsp_text_o,
  output logic                         rsp_err_o,
  output logic                         enc_ld_o,
  output logic [AES_BLK_W-1:0]         enc_key_o,
  output logic [AES_BLK_W-1:0]         enc_text_o,
  input  logic                         enc_done_i,
  input  logic [AES_BLK_W-1:0]         enc_text_i,
  output logic                         dec_kld_o,
  output logic                         dec_ld_o,
  output logic [AES_BLK_W-1:0]         dec_key_o,
  output logic [AES_BLK_W-1:0]         dec_text_o,
  input  logic                         dec_done_i,
  input  logic [AES_BLK_W-1:0]         dec_text_i,
  output logic                         busy_o,
  output state_e                       dbg_state
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int KW = (KEY_EXP_CYCLES > 1) ? $clog2(KEY_EXP_CYCLES) : 1;

  state_e               state;
  logic                 mode_q;
  logic [ID_W-1:0]      id_q;
  logic [ID_W-1:0]      ptr_q;
  logic [AES_BLK_W-1:0] key_q;
  logic [AES_BLK_W-1:0] text_q;
  logic [AES_BLK_W-1:0] cache_key_q;
  logic                 cache_vld_q;
  logic [TW-1:0]        timer_q;
  logic [KW-1:0]        kcnt_q;
  logic [AES_BLK_W-1:0] rsp_text_q;
  logic                 rsp_err_q;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 any_req;
  logic                 acc_mode;
  logic [AES_BLK_W-1:0] acc_key;
  logic [AES_BLK_W-1:0] acc_text;
  logic [ID_W-1:0]      ptr_next;
  logic                 sel_done;
  logic [AES_BLK_W-1:0] sel_text;

  aes_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req       (req_valid_i),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    acc_mode = MODE_ENC;
    acc_key  = '0;
    acc_text = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        acc_mode = req_mode_i[i];
        acc_key  = req_key_i[i*AES_BLK_W +: AES_BLK_W];
        acc_text = req_text_i[i*AES_BLK_W +: AES_BLK_W];
      end
    end
  end

  assign any_req  = |req_valid_i;
  assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Only the core that owns the current job may complete it.
  assign sel_done = (mode_q == MODE_DEC) ? dec_done_i : enc_done_i;
  assign sel_text = (mode_q == MODE_DEC) ? dec_text_i : enc_text_i;

  // Request side: a transfer happens on a rising edge where req_valid_i[i] and
  // req_ready_o[i] are both high; ready is offered only in IDLE and never while
  // reset is asserted. Response side: rsp_* is held until rsp_valid_o and
  // rsp_ready_i are both high on a rising edge.
  assign req_ready_o = (state == IDLE && rst) ? grant : '0;
  assign rsp_valid_o = (state == RESP);
  assign rsp_id_o    = id_q;
  assign rsp_text_o  = rsp_text_q;
  assign rsp_err_o   = rsp_err_q;
  assign enc_ld_o    = (state == ENC_LD);
  assign dec_kld_o   = (state == DEC_KLD);
  assign dec_ld_o    = (state == DEC_LD);
  assign enc_key_o   = key_q;
  assign enc_text_o  = text_q;
  assign dec_key_o   = key_q;
  assign dec_text_o  = text_q;
  assign busy_o      = (state != IDLE);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mode_q      <= MODE_ENC;
      id_q        <= '0;
      ptr_q       <= '0;
      key_q       <= '0;
      text_q      <= '0;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      timer_q     <= '0;
      kcnt_q      <= '0;
      rsp_text_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            mode_q <= acc_mode;
            key_q  <= acc_key;
            text_q <= acc_text;
            id_q   <= grant_idx;
            ptr_q  <= ptr_next;
            if (acc_mode == MODE_ENC) begin
              state <= ENC_LD;
            end else if (cache_vld_q && (cache_key_q == acc_key)) begin
              state <= DEC_LD;
            end else begin
              state <= DEC_KLD;
            end
          end
        end
        ENC_LD, DEC_LD: begin
          timer_q <= '0;
          state   <= WAIT;
        end
        DEC_KLD: begin
          cache_key_q <= key_q;
          cache_vld_q <= 1'b1;
          kcnt_q      <= '0;
          state       <= (KEY_EXP_CYCLES == 0) ? DEC_LD : DEC_KWAIT;
        end
        DEC_KWAIT: begin
          if (kcnt_q == KW'(KEY_EXP_CYCLES - 1)) begin
            state <= DEC_LD;
          end else begin
            kcnt_q <= kcnt_q + KW'(1);
          end
        end
        WAIT: begin
          // A done arriving on the last timeout cycle still counts as success.
          if (sel_done) begin
            rsp_text_q <= sel_text;
            rsp_err_q  <= 1'b0;
            state      <= RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rsp_text_q  <= '0;
            rsp_err_q   <= 1'b1;
            cache_vld_q <= 1'b0;
            state       <= RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
